// File: rtl/ov_7670_pkg.sv
// Shared state encoding, default timing and width helpers for the OV7670 emulator.
// Optional build macro used by the top level: OV_7670_EMU_PATTERN_EN.
package ov_7670_pkg;

    typedef enum logic [2:0] {
        IDLE,
        VSYNC,
        VBACK,
        ACTIVE,
        VFRONT
    } state_e;

    localparam int unsigned DEF_H_ACTIVE    = 640;
    localparam int unsigned DEF_V_ACTIVE    = 480;
    localparam int unsigned DEF_H_BLANK     = 144;
    localparam int unsigned DEF_VSYNC_LINES = 3;
    localparam int unsigned DEF_V_BACK      = 17;
    localparam int unsigned DEF_V_FRONT     = 10;
    localparam int unsigned DEF_ADDR_W      = 19;

    localparam int unsigned BYTES_PER_PIXEL = 2;

    function automatic int unsigned cnt_width(input int unsigned n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

    function automatic int unsigned max4(input int unsigned a, input int unsigned b,
                                         input int unsigned c, input int unsigned d);
        int unsigned m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        if (d > m) m = d;
        return m;
    endfunction

endpackage

// File: rtl/ov_7670_timing_gen.sv
// Line/frame sequencer: h and line counters plus the frame FSM.
// All outputs describe the upcoming cycle, so the top can register them and stay aligned.
module ov_7670_timing_gen
    import ov_7670_pkg::*;
#(
    parameter int unsigned H_ACTIVE    = DEF_H_ACTIVE,
    parameter int unsigned V_ACTIVE    = DEF_V_ACTIVE,
    parameter int unsigned H_BLANK     = DEF_H_BLANK,
    parameter int unsigned VSYNC_LINES = DEF_VSYNC_LINES,
    parameter int unsigned V_BACK      = DEF_V_BACK,
    parameter int unsigned V_FRONT     = DEF_V_FRONT,
    parameter int unsigned H_W         = cnt_width(BYTES_PER_PIXEL * H_ACTIVE + H_BLANK),
    parameter int unsigned L_W         = cnt_width(max4(VSYNC_LINES, V_BACK, V_ACTIVE, V_FRONT))
) (
    input  logic           pclk,
    input  logic           rst_n,
    input  logic           enable,
    output state_e         state,
    output logic [H_W-1:0] h,
    output logic [L_W-1:0] active_line,
    output logic           fetch,
    output logic           frame_end
);

    localparam int unsigned LINE_TOTAL = BYTES_PER_PIXEL * H_ACTIVE + H_BLANK;
    localparam logic [H_W-1:0] H_LAST       = H_W'(LINE_TOTAL - 1);
    localparam logic [H_W-1:0] H_PRE        = H_W'(LINE_TOTAL - 2);
    localparam logic [H_W-1:0] H_LAST_FETCH = H_W'(BYTES_PER_PIXEL * H_ACTIVE - 4);

    state_e         state_q, state_n;
    logic [H_W-1:0] h_q, h_n;
    logic [L_W-1:0] line_q, line_n, lines_m1;

    always_ff @(posedge pclk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            h_q     <= '0;
            line_q  <= '0;
        end else begin
            state_q <= state_n;
            h_q     <= h_n;
            line_q  <= line_n;
        end
    end

    always_comb begin
        state_n  = state_q;
        h_n      = '0;
        line_n   = '0;
        lines_m1 = '0;
        unique case (state_q)
            VSYNC:   lines_m1 = L_W'(VSYNC_LINES - 1);
            VBACK:   lines_m1 = L_W'(V_BACK - 1);
            ACTIVE:  lines_m1 = L_W'(V_ACTIVE - 1);
            VFRONT:  lines_m1 = L_W'(V_FRONT - 1);
            default: lines_m1 = '0;
        endcase

        if (state_q == IDLE) begin
            if (enable) state_n = VSYNC;
        end else if (h_q != H_LAST) begin
            h_n    = h_q + 1'b1;
            line_n = line_q;
        end else if (line_q != lines_m1) begin
            line_n = line_q + 1'b1;
        end else begin
            unique case (state_q)
                VSYNC:   state_n = VBACK;
                VBACK:   state_n = ACTIVE;
                ACTIVE:  state_n = VFRONT;
                VFRONT:  state_n = enable ? VSYNC : IDLE;
                default: state_n = IDLE;
            endcase
        end
    end

    // A fetch leads its high byte by two cycles, so line-start fetches land in the previous line's tail.
    always_comb begin
        state       = state_n;
        h           = h_n;
        active_line = line_n;
        fetch       = 1'b0;
        if (state_n == ACTIVE && !h_n[0] && h_n <= H_LAST_FETCH) begin
            fetch = 1'b1;
        end else if (h_n == H_PRE) begin
            if ((state_n == ACTIVE && line_n != L_W'(V_ACTIVE - 1)) ||
                (state_n == VBACK  && line_n == L_W'(V_BACK - 1)))
                fetch = 1'b1;
        end
        frame_end = (state_n == VFRONT) && (line_n == L_W'(V_FRONT - 1)) && (h_n == H_LAST);
    end

endmodule

// File: rtl/ov_7670_emulator.sv
// OV7670-style vsync/href/byte stream sourced from a frame-buffer read port.
// Define OV_7670_EMU_PATTERN_EN to replace memory pixels with a {line, column} test pattern.
module ov_7670_emulator
    import ov_7670_pkg::*;
#(
    parameter int unsigned H_ACTIVE    = DEF_H_ACTIVE,
    parameter int unsigned V_ACTIVE    = DEF_V_ACTIVE,
    parameter int unsigned H_BLANK     = DEF_H_BLANK,
    parameter int unsigned VSYNC_LINES = DEF_VSYNC_LINES,
    parameter int unsigned V_BACK      = DEF_V_BACK,
    parameter int unsigned V_FRONT     = DEF_V_FRONT,
    parameter int unsigned ADDR_W      = DEF_ADDR_W
) (
    input  logic              pclk,
    input  logic              rst_n,
    input  logic              enable,
    output logic              rd_en,
    output logic [ADDR_W-1:0] rd_addr,
    input  logic [15:0]       rd_data,
    output logic              vsync,
    output logic              href,
    output logic [7:0]        data,
    output logic              frame_done
);

    localparam int unsigned LINE_TOTAL = BYTES_PER_PIXEL * H_ACTIVE + H_BLANK;
    localparam int unsigned H_W        = cnt_width(LINE_TOTAL);
    localparam int unsigned L_W        = cnt_width(max4(VSYNC_LINES, V_BACK, V_ACTIVE, V_FRONT));
    localparam logic [H_W-1:0] HREF_END = H_W'(BYTES_PER_PIXEL * H_ACTIVE);

    state_e         state;
    logic [H_W-1:0] h;
    logic [L_W-1:0] active_line;
    logic           fetch;
    logic           frame_end;
    logic           href_n;
    logic           frame_start;
    logic [15:0]    pixel;
    logic [7:0]     lo_q;

    ov_7670_timing_gen #(
        .H_ACTIVE    (H_ACTIVE),
        .V_ACTIVE    (V_ACTIVE),
        .H_BLANK     (H_BLANK),
        .VSYNC_LINES (VSYNC_LINES),
        .V_BACK      (V_BACK),
        .V_FRONT     (V_FRONT),
        .H_W         (H_W),
        .L_W         (L_W)
    ) u_timing (
        .pclk        (pclk),
        .rst_n       (rst_n),
        .enable      (enable),
        .state       (state),
        .h           (h),
        .active_line (active_line),
        .fetch       (fetch),
        .frame_end   (frame_end)
    );

    assign href_n      = (state == ACTIVE) && (h < HREF_END);
    assign frame_start = (state == VSYNC) && (h == '0) && (active_line == '0);

`ifdef OV_7670_EMU_PATTERN_EN
    localparam logic MEM_MODE = 1'b0;
    logic [15:0] line_ext, col_ext;

    always_comb begin
        line_ext = 16'(active_line);
        col_ext  = 16'(h >> 1);
        pixel    = {line_ext[7:0], col_ext[7:0]};
    end
`else
    localparam logic MEM_MODE = 1'b1;

    // rd_data is valid exactly in the cycle that loads the high byte.
    assign pixel = rd_data;
`endif

    always_ff @(posedge pclk or negedge rst_n) begin
        if (!rst_n) begin
            rd_en      <= 1'b0;
            rd_addr    <= '0;
            vsync      <= 1'b0;
            href       <= 1'b0;
            data       <= '0;
            lo_q       <= '0;
            frame_done <= 1'b0;
        end else begin
            rd_en      <= fetch && MEM_MODE;
            vsync      <= (state == VSYNC);
            href       <= href_n;
            frame_done <= frame_end;

            if (state == IDLE || frame_start)
                rd_addr <= '0;
            else if (rd_en)
                rd_addr <= rd_addr + 1'b1;

            if (href_n) begin
                if (!h[0]) begin
                    data <= pixel[15:8];
                    lo_q <= pixel[7:0];
                end else begin
                    data <= lo_q;
                end
            end else begin
                data <= '0;
            end
        end
    end

endmodule

// File: tb/tb_ov_7670_emulator.sv
// Directed bench for ov_7670_emulator with small frame geometry (14-cycle lines, 84-cycle frames).
module tb_ov_7670_emulator;

    localparam int unsigned H_ACTIVE    = 4;
    localparam int unsigned V_ACTIVE    = 3;
    localparam int unsigned H_BLANK     = 6;
    localparam int unsigned VSYNC_LINES = 1;
    localparam int unsigned V_BACK      = 1;
    localparam int unsigned V_FRONT     = 1;
    localparam int unsigned ADDR_W      = 19;
    localparam int unsigned LT          = 14;
    localparam int unsigned FRAME       = 84;
    localparam int unsigned NO_DROP     = 32'hFFFF_FFFF;

    logic              pclk = 1'b0;
    logic              rst_n = 1'b0;
    logic              enable = 1'b0;
    logic              rd_en;
    logic [ADDR_W-1:0] rd_addr;
    logic [15:0]       rd_data = 16'hDEAD;
    logic              vsync;
    logic              href;
    logic [7:0]        data;
    logic              frame_done;

    int unsigned n_vec = 0;
    int unsigned n_bad = 0;

    ov_7670_emulator #(
        .H_ACTIVE    (H_ACTIVE),
        .V_ACTIVE    (V_ACTIVE),
        .H_BLANK     (H_BLANK),
        .VSYNC_LINES (VSYNC_LINES),
        .V_BACK      (V_BACK),
        .V_FRONT     (V_FRONT),
        .ADDR_W      (ADDR_W)
    ) dut (
        .pclk       (pclk),
        .rst_n      (rst_n),
        .enable     (enable),
        .rd_en      (rd_en),
        .rd_addr    (rd_addr),
        .rd_data    (rd_data),
        .vsync      (vsync),
        .href       (href),
        .data       (data),
        .frame_done (frame_done)
    );

    always #5 pclk = ~pclk;

    // Frame-buffer model: one-cycle read latency, contents A000 + address.
    always @(posedge pclk)
        rd_data <= rd_en ? (16'hA000 + 16'(rd_addr)) : 16'hDEAD;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s @%0t: got 0x%0h, want 0x%0h", tag, $time, got, exp);
        end
    endtask

    // Expected outputs at frame-relative cycle u (u=0 is the first vsync-high cycle).
    task automatic check_frame_cycle(input int unsigned u);
        int unsigned ln, hh, fu, fln, fhh;
        logic        e_href, e_rden;
        logic [7:0]  e_data;
        ln     = u / LT;
        hh     = u % LT;
        fu     = u + 2;
        fln    = fu / LT;
        fhh    = fu % LT;
        e_href = (ln >= 2) && (ln < 5) && (hh < 8);
        e_data = 8'h00;
`ifdef OV_7670_EMU_PATTERN_EN
        e_rden = 1'b0;
        if (e_href) e_data = (hh % 2 == 0) ? 8'(ln - 2) : 8'(hh / 2);
        check("rd_addr_pat", 32'(rd_addr), 32'd0);
`else
        e_rden = (fu < FRAME) && (fln >= 2) && (fln < 5) && (fhh < 8) && (fhh % 2 == 0);
        if (e_href) e_data = (hh % 2 == 0) ? 8'hA0 : 8'((ln - 2) * 4 + hh / 2);
        if (e_rden) check("rd_addr", 32'(rd_addr), 32'((fln - 2) * 4 + fhh / 2));
        if (ln == 0) check("rd_addr_vsync", 32'(rd_addr), 32'd0);
`endif
        check("vsync", 32'(vsync), 32'(u < LT));
        check("href", 32'(href), 32'(e_href));
        check("data", 32'(data), 32'(e_data));
        check("rd_en", 32'(rd_en), 32'(e_rden));
        check("frame_done", 32'(frame_done), 32'(u == FRAME - 1));
    endtask

    task automatic run_frames(input int unsigned nf, input int unsigned drop_at);
        for (int unsigned t = 0; t < nf * FRAME; t++) begin
            @(negedge pclk);
            check_frame_cycle(t % FRAME);
            if (t == drop_at) enable = 1'b0;
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_vsync"}, 32'(vsync), 32'd0);
        check({tag, "_href"}, 32'(href), 32'd0);
        check({tag, "_data"}, 32'(data), 32'd0);
        check({tag, "_rd_en"}, 32'(rd_en), 32'd0);
        check({tag, "_rd_addr"}, 32'(rd_addr), 32'd0);
        check({tag, "_frame_done"}, 32'(frame_done), 32'd0);
    endtask

    initial begin
        repeat (3) @(negedge pclk);
        check_all_zero("reset");
        rst_n = 1'b1;
        repeat (4) @(negedge pclk);
        check_all_zero("idle");

        // Three back-to-back frames; enable drops in the second ACTIVE line of the third.
        enable = 1'b1;
        run_frames(3, 2 * FRAME + 3 * LT + 1);
        repeat (20) begin
            @(negedge pclk);
            check_all_zero("after_drop");
        end

        // Restart, then hit reset in the middle of an active line.
        enable = 1'b1;
        for (int unsigned u = 0; u <= 3 * LT + 2; u++) begin
            @(negedge pclk);
            check_frame_cycle(u);
        end
        #2 rst_n = 1'b0;
        #1 check_all_zero("async_rst");
        @(negedge pclk);
        rst_n = 1'b1;
        run_frames(1, NO_DROP);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
